// File: rtl/nibble_serial_sub16_pkg.sv
// Shared definitions for the nibble-serial subtractor: state encodings,
// default geometry and the signed-overflow helper.
package nibble_serial_sub16_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int WIDTH_DEF = 16;
   localparam int SLICE_DEF = 4;

   // Two's-complement overflow of a - b: operand signs differ and the result sign left a's.
   function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
      return (a_msb ^ b_msb) & (d_msb ^ a_msb);
   endfunction

endpackage

// File: rtl/nibble_serial_sub16_fs4.sv
// Combinational SLICE-bit full subtractor: {Bo, D} = A - B - Bi.
module fs4 #(
   parameter int SLICE = 4
) (
   input  logic [SLICE-1:0] A,
   input  logic [SLICE-1:0] B,
   input  logic             Bi,
   output logic [SLICE-1:0] D,
   output logic             Bo
);

   logic [SLICE:0] w_diff;

   // One extra bit catches the borrow as the sign of the widened difference.
   assign w_diff = {1'b0, A} - {1'b0, B} - {{SLICE{1'b0}}, Bi};
   assign D      = w_diff[SLICE-1:0];
   assign Bo     = w_diff[SLICE];

endmodule

// File: rtl/nibble_serial_sub16.sv
// Multi-cycle WIDTH-bit subtractor reusing one SLICE-bit full subtractor,
// LSB slice first, with start/done handshake and registered result flags.
module nibble_serial_sub16
   import nibble_serial_sub16_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int SLICE = SLICE_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bi,
   output logic [WIDTH-1:0] D,
   output logic             Bo,
   output logic             V,
   output logic             Z,
   output logic             busy,
   output logic             done
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_brw;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_d;
   logic             r_bo;
   logic             r_v;
   logic             r_z;

   logic             w_accept;
   logic             w_last;
   logic [SLICE-1:0] w_a_sl;
   logic [SLICE-1:0] w_b_sl;
   logic [SLICE-1:0] w_fs_d;
   logic             w_fs_bo;
   logic [WIDTH-1:0] w_acc_nxt;

   assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
   assign w_last   = (r_cnt == CNT_W'(NSLICE - 1));
   assign w_a_sl   = r_a[r_cnt*SLICE +: SLICE];
   assign w_b_sl   = r_b[r_cnt*SLICE +: SLICE];

   fs4 #(
      .SLICE (SLICE)
   ) u_fs4 (
      .A  (w_a_sl),
      .B  (w_b_sl),
      .Bi (r_brw),
      .D  (w_fs_d),
      .Bo (w_fs_bo)
   );

   // Accumulator with the current slice merged in; on the last slice this is the full result.
   always_comb begin
      w_acc_nxt                        = r_acc;
      w_acc_nxt[r_cnt*SLICE +: SLICE]  = w_fs_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_d     <= '0;
         r_bo    <= 1'b0;
         r_v     <= 1'b0;
         r_z     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state <= ST_RUN;
                  r_cnt   <= '0;
               end
            end
            ST_RUN: begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_state <= ST_DONE;
                  r_d     <= w_acc_nxt;
                  r_bo    <= w_fs_bo;
                  r_v     <= sub_ovf(r_a[WIDTH-1], r_b[WIDTH-1], w_acc_nxt[WIDTH-1]);
                  r_z     <= (w_acc_nxt == '0);
               end
            end
            ST_DONE: begin
               r_cnt   <= '0;
               r_state <= start ? ST_RUN : ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   // Datapath registers carry no reset; an accepted start always reloads them.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_a   <= A;
         r_b   <= B;
         r_brw <= Bi;
         r_acc <= '0;
      end else if (r_state == ST_RUN) begin
         r_acc <= w_acc_nxt;
         r_brw <= w_fs_bo;
      end
   end

   assign D    = r_d;
   assign Bo   = r_bo;
   assign V    = r_v;
   assign Z    = r_z;
   assign busy = (r_state == ST_RUN);
   assign done = (r_state == ST_DONE);

endmodule

// File: tb/tb_nibble_serial_sub16.sv
// Directed bench for nibble_serial_sub16: vector table plus handshake corner sequences.
module tb_nibble_serial_sub16;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        bi;
      logic [15:0] d;
      logic        bo;
      logic        v;
      logic        z;
   } vec_t;

   logic        clk;
   logic        reset;
   logic        start;
   logic [15:0] A;
   logic [15:0] B;
   logic        Bi;
   logic [15:0] D;
   logic        Bo;
   logic        V;
   logic        Z;
   logic        busy;
   logic        done;

   int checks;
   int errors;

   vec_t vecs [9];

   nibble_serial_sub16 dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .A     (A),
      .B     (B),
      .Bi    (Bi),
      .D     (D),
      .Bo    (Bo),
      .V     (V),
      .Z     (Z),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_res(input string name, input vec_t e);
      chk({name, ".D"},  32'(D),  32'(e.d));
      chk({name, ".Bo"}, 32'(Bo), 32'(e.bo));
      chk({name, ".V"},  32'(V),  32'(e.v));
      chk({name, ".Z"},  32'(Z),  32'(e.z));
   endtask

   // Issue one op from a negedge; checks busy window, done pulse and result, returns at the negedge after done.
   task automatic run_op(input string name, input vec_t e);
      A = e.a; B = e.b; Bi = e.bi; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         chk({name, ".busy"}, 32'(busy), 32'd1);
         chk({name, ".early_done"}, 32'(done), 32'd0);
         @(negedge clk);
      end
      chk({name, ".done"}, 32'(done), 32'd1);
      chk({name, ".busy_off"}, 32'(busy), 32'd0);
      chk_res(name, e);
      @(negedge clk);
      chk({name, ".done_pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      int ndone;
      vec_t e;
      checks = 0;
      errors = 0;

      vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
      vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
      vecs[8] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0, 1'b0};

      reset = 1'b1; start = 1'b0; A = '0; B = '0; Bi = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("rst.D", 32'(D), 32'd0);
      chk("rst.flags", 32'({Bo, V, Z}), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.done", 32'(done), 32'd0);

      for (int i = 0; i < 9; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i]);
      end

      // Start pulses and operand changes during RUN are ignored.
      A = 16'h00FF; B = 16'h000F; Bi = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      A = 16'hFFFF; B = 16'hFFFF; Bi = 1'b1;
      ndone = 0;
      for (int k = 1; k <= 8; k++) begin
         start = (k <= 2);
         if (k <= 4) chk("ign.hold_D", 32'(D), 32'h9999);
         if (done) ndone++;
         @(negedge clk);
      end
      start = 1'b0;
      chk("ign.ndone", 32'(ndone), 32'd1);
      chk_res("ign", '{16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0});

      // Start asserted in the DONE cycle is accepted back-to-back.
      A = 16'h0010; B = 16'h0001; Bi = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("b2b.first_done", 32'(done), 32'd1);
      chk("b2b.first_D", 32'(D), 32'h000F);
      A = 16'h0003; B = 16'h0001; Bi = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("b2b.busy_next", 32'(busy), 32'd1);
      ndone = 0;
      for (int k = 1; k <= 4; k++) begin
         chk("b2b.hold_D", 32'(D), 32'h000F);
         if (done) ndone++;
         @(negedge clk);
      end
      chk("b2b.no_early_done", 32'(ndone), 32'd0);
      chk("b2b.second_done", 32'(done), 32'd1);
      chk("b2b.second_D", 32'(D), 32'h0002);
      @(negedge clk);

      // Reset in the second RUN cycle aborts with no done pulse.
      run_op("pre_rst", vecs[6]);
      A = 16'h1234; B = 16'h0234; Bi = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("abort.busy_run2", 32'(busy), 32'd1);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("abort.D", 32'(D), 32'd0);
      chk("abort.flags", 32'({Bo, V, Z}), 32'd0);
      chk("abort.busy", 32'(busy), 32'd0);
      ndone = 0;
      for (int k = 0; k < 6; k++) begin
         if (done || busy) ndone++;
         @(negedge clk);
      end
      chk("abort.idle", 32'(ndone), 32'd0);
      e = '{16'h0003, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};
      run_op("post_rst", e);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
